// File: rtl/vermi_memory_if.sv
// Request/response bus between a master and a vermi_memory slave.
// Handshake: the master raises valid and holds address, wstrobe and wdata stable until it sees
// ready; ready is a one-cycle pulse that completes the transfer, and rdata is meaningful only
// while ready=1 on a read (wstrobe==0). Dropping valid before ready abandons the request.
interface vermi_memory_if;
  logic        valid;
  logic [31:0] address;
  logic [3:0]  wstrobe;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output valid, address, wstrobe, wdata, input rdata, ready);
  modport slave  (input valid, address, wstrobe, wdata, output rdata, ready);
endinterface

// File: rtl/vermi_memory.sv
// Word-organised memory slave with byte-lane writes and a one-cycle ready pulse.
// Define VERMI_MEMORY_WAIT_EN to insert LATENCY wait cycles before each response.
module vermi_memory #(
  parameter int unsigned SIZE_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int unsigned LATENCY      = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  vermi_memory_if.slave bus,
  output logic [1:0]   dbg_state
);

  localparam int unsigned AW   = (SIZE_WORDS > 1) ? $clog2(SIZE_WORDS) : 1;
  localparam logic [32:0] SPAN = 33'(SIZE_WORDS) * 33'd4;

`ifdef VERMI_MEMORY_WAIT_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESPOND = 2'd2} state_t;
  localparam logic [3:0] LAT = (LATENCY > 15) ? 4'd15 : 4'(LATENCY);
  logic [3:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RESPOND = 2'd2} state_t;
`endif

  state_t          state_q, state_d;
  logic            enter_respond;
  logic [31:0]     offset;
  logic            selected;
  logic [AW-1:0]   word_idx;
  logic [31:0]     rdata_q;
  logic [31:0]     mem [SIZE_WORDS];

  // Addresses below the base wrap to large offsets and fall outside the span.
  assign offset   = bus.address - BASE_ADDRESS;
  assign selected = bus.valid && ({1'b0, offset} < SPAN);
  assign word_idx = offset[AW+1:2];

  assign bus.ready = (state_q == ST_RESPOND);
  assign bus.rdata = rdata_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d       = state_q;
    enter_respond = 1'b0;
`ifdef VERMI_MEMORY_WAIT_EN
    cnt_d         = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (selected) begin
`ifdef VERMI_MEMORY_WAIT_EN
          if (LAT == 4'd0) begin
            state_d       = ST_RESPOND;
            enter_respond = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = LAT - 4'd1;
          end
`else
          state_d       = ST_RESPOND;
          enter_respond = 1'b1;
`endif
        end
      end
`ifdef VERMI_MEMORY_WAIT_EN
      ST_WAIT: begin
        if (!bus.valid) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d       = ST_RESPOND;
          enter_respond = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
`ifdef VERMI_MEMORY_WAIT_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
`ifdef VERMI_MEMORY_WAIT_EN
      cnt_q   <= cnt_d;
`endif
      // rdata only carries a word for the single RESPOND cycle of a read.
      if (enter_respond && (bus.wstrobe == 4'b0000)) rdata_q <= mem[word_idx];
      else                                           rdata_q <= '0;
    end
  end

  // Contents survive reset; the reset_n term blocks a write while reset is held.
  always_ff @(posedge clk) begin
    if (reset_n && enter_respond) begin
      for (int n = 0; n < 4; n++) begin
        if (bus.wstrobe[n]) mem[word_idx][8*n +: 8] <= bus.wdata[8*n +: 8];
      end
    end
  end

endmodule

// File: tb/tb_vermi_memory.sv
// Directed bench for vermi_memory: one zero-latency instance and one LATENCY=3 instance.
module tb_vermi_memory;

`ifdef VERMI_MEMORY_WAIT_EN
  localparam int LAT3_CYC = 4;
`else
  localparam int LAT3_CYC = 1;
`endif

  logic clk;
  logic reset_n;
  logic [1:0] dbg0, dbg3;
  int n_cmp;
  int n_fail;

  vermi_memory_if b0();
  vermi_memory_if b3();

  vermi_memory #(.SIZE_WORDS(1024), .BASE_ADDRESS(32'h0000_0000), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset_n(reset_n), .bus(b0), .dbg_state(dbg0)
  );

  vermi_memory #(.SIZE_WORDS(256), .BASE_ADDRESS(32'h0001_0000), .LATENCY(3)) u_lat3 (
    .clk(clk), .reset_n(reset_n), .bus(b3), .dbg_state(dbg3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_cyc(input int sel);
    return (sel == 0) ? 1 : LAT3_CYC;
  endfunction

  // driver: one complete transfer, returns cycles-to-ready (-1 on timeout) and sampled rdata
  task automatic do_xfer(input int sel, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] data, output logic [31:0] rd, output int cyc);
    logic rdy;
    @(negedge clk);
    if (sel == 0) begin
      b0.valid = 1'b1; b0.address = addr; b0.wstrobe = strb; b0.wdata = data;
    end else begin
      b3.valid = 1'b1; b3.address = addr; b3.wstrobe = strb; b3.wdata = data;
    end
    cyc = -1;
    rd  = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      rdy = (sel == 0) ? b0.ready : b3.ready;
      if (rdy) begin
        cyc = i;
        rd  = (sel == 0) ? b0.rdata : b3.rdata;
        break;
      end
    end
    @(negedge clk);
    if (sel == 0) b0.valid = 1'b0; else b3.valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    b0.valid = 1'b0; b0.address = '0; b0.wstrobe = '0; b0.wdata = '0;
    b3.valid = 1'b0; b3.address = '0; b3.wstrobe = '0; b3.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (b0.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %b expected 0", b0.ready); end
    n_cmp++; if (b0.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata0: got %h expected 0", b0.rdata); end
    n_cmp++; if (dbg0 !== 2'd0) begin n_fail++; $display("FAIL reset_state0: got %0d expected 0", dbg0); end
    n_cmp++; if (b3.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready3: got %b expected 0", b3.ready); end
    n_cmp++; if (b3.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata3: got %h expected 0", b3.rdata); end
    n_cmp++; if (dbg3 !== 2'd0) begin n_fail++; $display("FAIL reset_state3: got %0d expected 0", dbg3); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    int cyc;
    do_xfer(0, 32'h100, 4'b1111, 32'h0000_0096, rd, cyc);
    n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL wr_latency: got %0d expected 1", cyc); end
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL wr_rdata_zero: got %h expected 0", rd); end
    do_xfer(0, 32'h100, 4'b0000, 32'h0, rd, cyc);
    n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL rd_latency: got %0d expected 1", cyc); end
    n_cmp++; if (rd !== 32'h0000_0096) begin n_fail++; $display("FAIL rd_data: got %h expected 00000096", rd); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] off [5];
    logic [3:0]  strb[5];
    logic [31:0] dat [5];
    logic [31:0] exp_rd[5];
    logic [31:0] base, rd;
    int sel, cyc;
    off    = '{32'h0, 32'h2, 32'h0, 32'h0, 32'h2};
    strb   = '{4'b1111, 4'b1100, 4'b0001, 4'b0000, 4'b0000};
    dat    = '{32'h8C15_F3E4, 32'h0096_0096, 32'h9696_9696, 32'h0, 32'h0};
    exp_rd = '{32'h0, 32'h0, 32'h0, 32'h0096_F396, 32'h0096_F396};
    for (int s = 0; s < 2; s++) begin
      sel  = (s == 0) ? 0 : 3;
      base = (s == 0) ? 32'h0000_0200 : 32'h0001_0100;
      for (int k = 0; k < 5; k++) begin
        do_xfer(sel, base + off[k], strb[k], dat[k], rd, cyc);
        n_cmp++;
        if (cyc !== exp_cyc(sel)) begin
          n_fail++; $display("FAIL lanes_latency[%0d,%0d]: got %0d expected %0d", sel, k, cyc, exp_cyc(sel));
        end
        n_cmp++;
        if (rd !== exp_rd[k]) begin
          n_fail++; $display("FAIL lanes_rdata[%0d,%0d]: got %h expected %h", sel, k, rd, exp_rd[k]);
        end
      end
    end
  endtask

  task automatic test_latency();
    logic r0[1:20];
    logic r3[1:20];
    logic [31:0] d0, d3;
    int f0, s0, f3, s3;
    @(negedge clk);
    b0.valid = 1'b1; b0.address = 32'h100;     b0.wstrobe = 4'b0000; b0.wdata = '0;
    b3.valid = 1'b1; b3.address = 32'h0001_0100; b3.wstrobe = 4'b0000; b3.wdata = '0;
    f0 = -1; s0 = -1; f3 = -1; s3 = -1; d0 = '0; d3 = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      r0[i] = b0.ready;
      r3[i] = b3.ready;
      if (b0.ready) begin if (f0 < 0) begin f0 = i; d0 = b0.rdata; end else if (s0 < 0) s0 = i; end
      if (b3.ready) begin if (f3 < 0) begin f3 = i; d3 = b3.rdata; end else if (s3 < 0) s3 = i; end
    end
    @(negedge clk);
    b0.valid = 1'b0; b3.valid = 1'b0;
    repeat (8) @(posedge clk);
    n_cmp++; if (f0 !== 1) begin n_fail++; $display("FAIL lat0_first: got %0d expected 1", f0); end
    n_cmp++; if (s0 - f0 !== 2) begin n_fail++; $display("FAIL lat0_period: got %0d expected 2", s0 - f0); end
    n_cmp++; if (d0 !== 32'h96) begin n_fail++; $display("FAIL lat0_rdata: got %h expected 00000096", d0); end
    n_cmp++; if (f3 !== LAT3_CYC) begin n_fail++; $display("FAIL lat3_first: got %0d expected %0d", f3, LAT3_CYC); end
    n_cmp++;
    if (s3 - f3 !== LAT3_CYC + 1) begin
      n_fail++; $display("FAIL lat3_period: got %0d expected %0d", s3 - f3, LAT3_CYC + 1);
    end
    n_cmp++;
    if (f3 > 0 && f3 < 20 && r3[f3+1] !== 1'b0) begin
      n_fail++; $display("FAIL lat3_pulse: got %b expected 0", r3[f3+1]);
    end
    n_cmp++; if (d3 !== 32'h0096_F396) begin n_fail++; $display("FAIL lat3_rdata: got %h expected 0096f396", d3); end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    int cyc, nrdy;
    do_xfer(3, 32'h0001_0180, 4'b1111, 32'h1111_1111, rd, cyc);
    n_cmp++; if (cyc !== LAT3_CYC) begin n_fail++; $display("FAIL abort_preload: got %0d expected %0d", cyc, LAT3_CYC); end
`ifdef VERMI_MEMORY_WAIT_EN
    nrdy = 0;
    @(negedge clk);
    b3.valid = 1'b1; b3.address = 32'h0001_0180; b3.wstrobe = 4'b1111; b3.wdata = 32'hDEAD_BEEF;
    repeat (2) begin @(posedge clk); #1; if (b3.ready) nrdy++; end
    @(negedge clk);
    b3.valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (b3.ready) nrdy++; end
    n_cmp++; if (nrdy !== 0) begin n_fail++; $display("FAIL abort_no_ready: got %0d expected 0", nrdy); end
`endif
    do_xfer(3, 32'h0001_0180, 4'b0000, 32'h0, rd, cyc);
    n_cmp++; if (rd !== 32'h1111_1111) begin n_fail++; $display("FAIL abort_old_word: got %h expected 11111111", rd); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    int cyc, n0, n3;
    do_xfer(0, 32'h0000_0000, 4'b1111, 32'hA5A5_A5A5, rd, cyc);
    do_xfer(3, 32'h0001_0000, 4'b1111, 32'h5A5A_5A5A, rd, cyc);
    do_xfer(3, 32'h0001_03FC, 4'b1111, 32'h0BAD_CAFE, rd, cyc);
    n_cmp++; if (cyc !== LAT3_CYC) begin n_fail++; $display("FAIL oor_last_word_wr: got %0d expected %0d", cyc, LAT3_CYC); end
    @(negedge clk);
    b0.valid = 1'b1; b0.address = 32'h0000_1000; b0.wstrobe = 4'b1111; b0.wdata = 32'hFFFF_FFFF;
    b3.valid = 1'b1; b3.address = 32'h0000_FFFC; b3.wstrobe = 4'b1111; b3.wdata = 32'hFFFF_FFFF;
    n0 = 0; n3 = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (b0.ready) n0++;
      if (b3.ready) n3++;
      if (i == 10) b3.address = 32'h0001_0400;
    end
    @(negedge clk);
    b0.valid = 1'b0; b3.valid = 1'b0;
    n_cmp++; if (n0 !== 0) begin n_fail++; $display("FAIL oor_ready0: got %0d expected 0", n0); end
    n_cmp++; if (n3 !== 0) begin n_fail++; $display("FAIL oor_ready3: got %0d expected 0", n3); end
    do_xfer(0, 32'h0000_0000, 4'b0000, 32'h0, rd, cyc);
    n_cmp++; if (rd !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL oor_word0: got %h expected a5a5a5a5", rd); end
    do_xfer(3, 32'h0001_0000, 4'b0000, 32'h0, rd, cyc);
    n_cmp++; if (rd !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL oor_base_word: got %h expected 5a5a5a5a", rd); end
    do_xfer(3, 32'h0001_03FF, 4'b0000, 32'h0, rd, cyc);
    n_cmp++; if (rd !== 32'h0BAD_CAFE) begin n_fail++; $display("FAIL oor_last_word: got %h expected 0badcafe", rd); end
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] rd;
    int cyc, nrdy;
    // async reset while a zero-latency read is responding
    @(negedge clk);
    b0.valid = 1'b1; b0.address = 32'h100; b0.wstrobe = 4'b0000; b0.wdata = '0;
    @(posedge clk); #1;
    n_cmp++; if (b0.ready !== 1'b1) begin n_fail++; $display("FAIL rsp_ready: got %b expected 1", b0.ready); end
    n_cmp++; if (b0.rdata !== 32'h96) begin n_fail++; $display("FAIL rsp_rdata: got %h expected 00000096", b0.rdata); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (b0.ready !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_ready: got %b expected 0", b0.ready); end
    n_cmp++; if (b0.rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rsp_rdata: got %h expected 0", b0.rdata); end
    @(negedge clk);
    b0.valid = 1'b0; reset_n = 1'b1;
    do_xfer(0, 32'h100, 4'b0000, 32'h0, rd, cyc);
    n_cmp++; if (rd !== 32'h96) begin n_fail++; $display("FAIL mem_kept: got %h expected 00000096", rd); end

    // reset while a write is waiting
    do_xfer(3, 32'h0001_0200, 4'b1111, 32'h1234_5678, rd, cyc);
    @(negedge clk);
    b3.valid = 1'b1; b3.address = 32'h0001_0200; b3.wstrobe = 4'b1111; b3.wdata = 32'hCAFE_F00D;
`ifdef VERMI_MEMORY_WAIT_EN
    @(posedge clk); #1;
    n_cmp++; if (dbg3 !== 2'd1) begin n_fail++; $display("FAIL wait_state: got %0d expected 1", dbg3); end
`endif
    reset_n = 1'b0;
    #1;
    n_cmp++; if (b3.ready !== 1'b0) begin n_fail++; $display("FAIL rst_wait_ready: got %b expected 0", b3.ready); end
    n_cmp++; if (b3.rdata !== 32'h0) begin n_fail++; $display("FAIL rst_wait_rdata: got %h expected 0", b3.rdata); end
    n_cmp++; if (dbg3 !== 2'd0) begin n_fail++; $display("FAIL rst_wait_state: got %0d expected 0", dbg3); end
    nrdy = 0;
    repeat (3) begin @(posedge clk); #1; if (b3.ready) nrdy++; end
    n_cmp++; if (nrdy !== 0) begin n_fail++; $display("FAIL rst_hold_ready: got %0d expected 0", nrdy); end
    @(negedge clk);
    b3.valid = 1'b0; reset_n = 1'b1;
    do_xfer(3, 32'h0001_0200, 4'b0000, 32'h0, rd, cyc);
    n_cmp++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL rst_word_kept: got %h expected 12345678", rd); end
    do_xfer(3, 32'h0001_0200, 4'b1111, 32'hCAFE_F00D, rd, cyc);
    n_cmp++; if (cyc !== LAT3_CYC) begin n_fail++; $display("FAIL post_rst_wr: got %0d expected %0d", cyc, LAT3_CYC); end
    do_xfer(3, 32'h0001_0200, 4'b0000, 32'h0, rd, cyc);
    n_cmp++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL post_rst_rd: got %h expected cafef00d", rd); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_latency();
    test_abort();
    test_out_of_range();
    test_reset_mid_transfer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vermi_memory.md
VERMI_MEMORY -- requirements
Module: vermi_memory

Interface
REQ-001 SHALL have parameter SIZE_WORDS, default 1024; memory depth in 32-bit words, power of two.
REQ-002 SHALL have parameter BASE_ADDRESS, default 32'h00000000; byte address of word 0, aligned to SIZE_WORDS*4.
REQ-003 SHALL have parameter LATENCY, default 2; wait cycles inserted before ready, range 0..15.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port valid  input  1  master request pending.
REQ-007 SHALL have port address  input  32  byte address of the request.
REQ-008 SHALL have port wstrobe  input  4  byte-lane write enables; 4'b0000 means read.
REQ-009 SHALL have port wdata  input  32  write data, lane n on bits 8n+7:8n.
REQ-010 SHALL have port rdata  output  32  read data, valid only while ready=1.
REQ-011 SHALL have port ready  output  1  one-cycle transfer-complete pulse.

Function
REQ-012 SHALL decode selected = valid and address within [BASE_ADDRESS, BASE_ADDRESS+SIZE_WORDS*4); word index = (address-BASE_ADDRESS)[..:2]; address[1:0] ignored for indexing.
REQ-013 SHALL implement FSM IDLE, WAIT, RESPOND; ready=1 only in RESPOND.
REQ-014 IDLE: selected and wait count 0 -> RESPOND; selected and count>0 -> WAIT with 4-bit counter loaded to LATENCY-1; otherwise stay.
REQ-015 WAIT: counter decrements each cycle; counter==0 and valid -> RESPOND; valid=0 at any WAIT cycle -> IDLE, transfer aborted, no write.
REQ-016 RESPOND: lasts exactly one cycle, then IDLE unconditionally; a still-asserted valid starts a new transfer from IDLE, giving LATENCY+2 cycles per transfer.
REQ-017 Write (wstrobe!=0): on the edge entering RESPOND, each lane with wstrobe[n]=1 SHALL take wdata lane n; lanes with 0 unchanged.
REQ-018 Read (wstrobe==0): rdata SHALL be the addressed word, registered on the edge entering RESPOND, full 32 bits regardless of address[1:0].
REQ-019 rdata SHALL be 0 whenever ready=0 and during write responses.
REQ-020 address, wstrobe, wdata SHALL be sampled on the edge entering RESPOND; master holds them stable from valid until ready.
REQ-021 Unselected requests SHALL never assert ready and never modify memory.

Reset
REQ-022 reset_n=0 SHALL immediately force state IDLE, counter 0, ready 0, rdata 0.
REQ-023 Reset mid-WAIT or mid-RESPOND SHALL abort the transfer; no write occurs after reset assertion.
REQ-024 Memory contents SHALL NOT be reset.

Configuration
REQ-025 Macro VERMI_MEMORY_WAIT_EN defined: LATENCY honoured, WAIT state and counter present.
REQ-026 Macro VERMI_MEMORY_WAIT_EN undefined: LATENCY ignored, WAIT state and counter absent, IDLE -> RESPOND directly on selected (2 cycles per transfer).

Verification
REQ-027 LATENCY=0: reset, write 32'h00000096 wstrobe 1111 at 0x100, then read 0x100 -> ready one cycle after valid each, rdata=32'h00000096.
REQ-028 Byte lanes: write 32'h8C15F3E4 at 0x100, then wstrobe 1100 wdata 32'h00960096 at 0x102, wstrobe 0001 wdata 32'h96969696 at 0x100 -> read 0x100 returns 32'h0096F396.
REQ-029 LATENCY=3 with VERMI_MEMORY_WAIT_EN: read request held -> ready exactly 4 cycles after valid rises, single-cycle pulse; without macro -> 1 cycle.
REQ-030 Abort: LATENCY=3, write request, drop valid after 2 cycles -> no ready, subsequent read shows old word.
REQ-031 Out of range: BASE_ADDRESS=0, SIZE_WORDS=1024, valid with address 32'h00001000 for 20 cycles -> ready stays 0, memory unchanged.
REQ-032 Reset mid-WAIT: assert reset_n=0 during WAIT of a write -> ready/rdata 0 immediately, target word unchanged, next transfer after release completes normally.
